// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file constants and types for the MIPS datapath.
// Rev 1.0
`default_nettype none

package mips_pkg;

  localparam int REG_DATA_W    = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int REG_NUM       = 2 ** REG_ADDR_W;
  localparam int REG_ZERO_ADDR = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with zero-register override and,
// with REGFILE_WR_BYPASS_EN defined, write-through forwarding. Rev 1.0
`default_nettype none

module regfile_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]                   ra,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
  input  logic                                byp_en,
  input  logic [ADDR_W-1:0]                   wa,
  input  logic [DATA_W-1:0]                   wd,
  output logic [DATA_W-1:0]                   rd
);

  logic ra_is_zero;
  assign ra_is_zero = (ra == ADDR_W'(REG_ZERO_ADDR));

`ifdef REGFILE_WR_BYPASS_EN
  always_comb begin
    rd = regs[ra];
    if (byp_en && (wa == ra)) begin
      rd = wd;
    end
    // The zero register wins over forwarding, even when wa is also 0.
    if (ra_is_zero) begin
      rd = '0;
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_en, wa, wd};

  always_comb begin
    rd = regs[ra];
    if (ra_is_zero) begin
      rd = '0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mips_register_file.sv
// mips_register_file: 32x32 MIPS register file, 2 async read ports, 1 sync write port.
// Optional macro REGFILE_WR_BYPASS_EN enables write-through forwarding. Rev 1.0
`default_nettype none

module mips_register_file
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              i_we3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int NUM = 2 ** ADDR_W;

  // Entry 0 has no storage; it only exists as a constant in the read view.
  logic [DATA_W-1:0]           mem [1:NUM-1];
  logic [NUM-1:0][DATA_W-1:0]  regs;
  logic                        byp_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 1; i < NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (i_we3 && (wa != ADDR_W'(REG_ZERO_ADDR))) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    regs[0] = '0;
    for (int i = 1; i < NUM; i++) begin
      regs[i] = mem[i];
    end
  end

  // Forwarding must not leak write data while reset holds the array at zero.
  assign byp_en = i_we3 & i_rst_n;

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .ra     (ra1),
    .regs   (regs),
    .byp_en (byp_en),
    .wa     (wa),
    .wd     (wd),
    .rd     (rd1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .ra     (ra2),
    .regs   (regs),
    .byp_en (byp_en),
    .wa     (wa),
    .wd     (wd),
    .rd     (rd2)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: scoreboard-based self-checking bench for mips_register_file.
// Rev 1.0
`default_nettype none
`timescale 1ns/10ps

module tb_mips_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic        we3;
  logic [31:0] rd1, rd2;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  mips_register_file dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .ra1     (ra1),
    .ra2     (ra2),
    .wa      (wa),
    .wd      (wd),
    .i_we3   (we3),
    .rd1     (rd1),
    .rd2     (rd2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  // Drive both read addresses, queue the expected data, then compare after dly.
  task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                           input realtime dly);
    ra1 = a1;
    ra2 = a2;
    exp_q.push_back(ref_rd(a1));
    exp_q.push_back(ref_rd(a2));
    #(dly);
    check($sformatf("%s_rd1[%0d]", tag, a1), rd1, exp_q.pop_front());
    check($sformatf("%s_rd2[%0d]", tag, a2), rd2, exp_q.pop_front());
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wa  = a;
    wd  = d;
    we3 = 1'b1;
    @(posedge clk);
    if (a != 5'd0) model[a] = d;
    #1;
    we3 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    we3   = 1'b0;
    wa    = 5'd0;
    wd    = 32'h0;
    ra1   = 5'd0;
    ra2   = 5'd0;
    clear_model();

    // Reads are zero everywhere while reset is held from power-up.
    #2;
    for (int n = 0; n < 32; n++) read_pair("por", 5'(n), 5'(31 - n), 0.1);
    @(negedge clk);
    rst_n = 1'b1;

    // Write every register, then sweep back with writes disabled.
    for (int n = 0; n < 32; n++) write_reg(5'(n), 32'hA5A5_0000 + 32'(n));
    @(negedge clk);
    for (int n = 0; n < 32; n++) read_pair("sweep", 5'(n), 5'(n + 1), 1.0);

    // Zero register ignores writes.
    write_reg(5'd0, 32'hFFFF_FFFF);
    read_pair("zero", 5'd0, 5'd0, 1.0);

    // Write-enable low must leave reg5 untouched over several edges.
    @(negedge clk);
    wa  = 5'd5;
    wd  = 32'h1234_5678;
    we3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_pair("we_gate", 5'd5, 5'd5, 1.0);

    // Read-during-write on the same address from both ports.
    write_reg(5'd7, 32'h0000_0007);
    @(negedge clk);
    ra1 = 5'd7;
    ra2 = 5'd7;
    wa  = 5'd7;
    wd  = 32'hDEAD_BEEF;
    we3 = 1'b1;
`ifdef REGFILE_WR_BYPASS_EN
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
`else
    exp_q.push_back(32'h0000_0007);
    exp_q.push_back(32'h0000_0007);
`endif
    #1;
    check("rdw_pre_rd1", rd1, exp_q.pop_front());
    check("rdw_pre_rd2", rd2, exp_q.pop_front());
    @(posedge clk);
    model[7] = 32'hDEAD_BEEF;
    #1;
    we3 = 1'b0;
    read_pair("rdw_post", 5'd7, 5'd7, 1.0);

    // Forwarding never overrides address 0.
    @(negedge clk);
    wa  = 5'd0;
    wd  = 32'hCAFE_F00D;
    we3 = 1'b1;
    read_pair("byp_zero", 5'd0, 5'd0, 1.0);
    we3 = 1'b0;

    // Asynchronous reset pulse between edges clears everything before the next edge.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    clear_model();
    for (int n = 0; n < 32; n++) read_pair("async_rst", 5'(n), 5'(31 - n), 0.1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset coincident with a write edge discards that write.
    write_reg(5'd3, 32'h0303_0303);
    write_reg(5'd9, 32'h0909_0909);
    @(negedge clk);
    read_pair("pre_mid", 5'd3, 5'd9, 1.0);
    wa  = 5'd3;
    wd  = 32'h3333_3333;
    we3 = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    clear_model();
    #1;
    we3 = 1'b0;
    for (int n = 0; n < 32; n++) read_pair("mid_rst", 5'(n), 5'(n), 0.1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    read_pair("post_mid", 5'd3, 5'd9, 1.0);

    // Fresh write after reset recovery.
    write_reg(5'd31, 32'h8000_0001);
    read_pair("recover", 5'd31, 5'd3, 1.0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
